// File: rtl/hi_sim_miller_rx.sv
// ============================================================================
// Module   : hi_sim_miller_rx
// Purpose  : ISO 14443A (106 kbit/s) modified-Miller reader->tag demodulator.
//            Optional CRC_A frame check enabled by macro HI_SIM_RX_CRC_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hi_sim_miller_rx #(
  parameter int BIT_PERIOD = 128,
  parameter int PAUSE_MIN  = 6,
  parameter int TOL        = 16,
  parameter int PAUSE_MAX  = 64
) (
  input  logic       ck_1356meg,
  input  logic       rst_n,
  input  logic       carrier_in,
  output logic [7:0] rx_data,
  output logic [3:0] rx_bits,
  output logic       rx_valid,
  output logic       rx_parity_err,
  output logic       rx_sof,
  output logic       rx_eof,
  output logic       rx_err,
  output logic       rx_busy,
  output logic       rx_crc_ok
);

  localparam int c_pw  = $clog2(BIT_PERIOD);
  localparam int c_lw  = $clog2(PAUSE_MAX + 1);
  localparam int c_dly = PAUSE_MIN + 2;

  localparam logic [c_pw-1:0] c_ph_d    = c_pw'(c_dly);
  localparam logic [c_pw-1:0] c_ph_last = c_pw'(BIT_PERIOD - 1);
  localparam logic [c_pw-1:0] c_z_lim   = c_pw'(c_dly + TOL);
  localparam logic [c_pw-1:0] c_x_lo    = c_pw'(BIT_PERIOD / 2 + c_dly - TOL);
  localparam logic [c_pw-1:0] c_x_hi    = c_pw'(BIT_PERIOD / 2 + c_dly + TOL);
  localparam logic [c_pw-1:0] c_early   = c_pw'(BIT_PERIOD - TOL);

  localparam logic [c_lw-1:0] c_low_evt = c_lw'(PAUSE_MIN - 1);
  localparam logic [c_lw-1:0] c_low_max = c_lw'(PAUSE_MAX - 1);
  localparam logic [c_lw-1:0] c_low_sat = c_lw'(PAUSE_MAX);

  localparam logic [0:0] c_s_idle = 1'b0;
  localparam logic [0:0] c_s_rx   = 1'b1;

  localparam logic [1:0] c_cell_y = 2'd0;
  localparam logic [1:0] c_cell_x = 2'd1;
  localparam logic [1:0] c_cell_z = 2'd2;

  logic [1:0]      r_sync;
  logic [c_lw-1:0] r_low_cnt;
  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic [c_pw-1:0] r_ph;
  logic [1:0]      r_cell;
  logic            r_skip;
  logic            r_prev;
  logic            r_pend_vld;
  logic            r_pend_bit;
  logic [7:0]      r_shift;
  logic [3:0]      r_bit_cnt;

  logic [7:0]      r_rx_data;
  logic [3:0]      r_rx_bits;
  logic            r_rx_valid;
  logic            r_rx_parity_err;
  logic            r_rx_sof;
  logic            r_rx_eof;
  logic            r_rx_err;

  logic            w_low;
  logic            w_evt;
  logic            w_loss;
  logic            w_in_rx;
  logic [c_pw-1:0] w_ph_next;
  logic            w_wrap;
  logic            w_z_cur;
  logic            w_z_early;
  logic            w_x;
  logic            w_bad;
  logic            w_close;
  logic            w_dec_bit;
  logic            w_dec_eof;
  logic            w_dec_err;
  logic            w_err;
  logic            w_sof;
  logic            w_eof;
  logic            w_bit_ok;
  logic            w_emit;
  logic            w_byte;
  logic            w_busy;

  // Synchroniser and low-run counter; the counter saturates so a long pause
  // produces exactly one pause event and one carrier-loss event.
  always_ff @(posedge ck_1356meg) begin
    if (!rst_n) begin
      r_sync    <= 2'b11;
      r_low_cnt <= '0;
    end else begin
      r_sync <= {r_sync[0], carrier_in};
      if (r_sync[1])
        r_low_cnt <= '0;
      else if (r_low_cnt != c_low_sat)
        r_low_cnt <= r_low_cnt + 1'b1;
    end
  end

  assign w_low  = ~r_sync[1];
  assign w_evt  = w_low && (r_low_cnt == c_low_evt);
  assign w_loss = w_low && (r_low_cnt == c_low_max);

  always_comb begin
    w_in_rx   = (r_state == c_s_rx);
    w_wrap    = (r_ph == c_ph_last);
    w_ph_next = w_wrap ? '0 : r_ph + 1'b1;
    w_z_cur   = w_in_rx && w_evt && (w_ph_next < c_z_lim);
    w_z_early = w_in_rx && w_evt && !w_z_cur && (w_ph_next >= c_early);
    w_x       = w_in_rx && w_evt && !w_z_cur && !w_z_early &&
                (w_ph_next >= c_x_lo) && (w_ph_next <= c_x_hi);
    w_bad     = w_in_rx && w_evt && !w_z_cur && !w_z_early && !w_x;
    w_close   = w_in_rx && (w_wrap || w_z_early);

    w_dec_bit = 1'b0;
    w_dec_eof = 1'b0;
    w_dec_err = 1'b0;
    // The SOF cell carries no data and is skipped at its close.
    if (w_close && !r_skip) begin
      case (r_cell)
        c_cell_x: w_dec_bit = 1'b1;
        c_cell_z: w_dec_err = r_prev;
        default:  w_dec_eof = ~r_prev;
      endcase
    end

    w_err    = w_in_rx && (w_loss || w_bad || w_dec_err);
    w_sof    = !w_in_rx && w_evt;
    w_eof    = w_close && !r_skip && w_dec_eof && !w_err;
    w_bit_ok = w_close && !r_skip && !w_dec_eof && !w_err;
    w_emit   = w_bit_ok && r_pend_vld;
    w_byte   = w_emit && (r_bit_cnt == 4'd8);
  end

  always_ff @(posedge ck_1356meg) begin
    if (!rst_n)
      r_state <= c_s_idle;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_s_idle: if (w_sof) w_state_nxt = c_s_rx;
      c_s_rx:   if (w_err || w_eof) w_state_nxt = c_s_idle;
      default:  w_state_nxt = c_s_idle;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      c_s_rx:  w_busy = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  always_ff @(posedge ck_1356meg) begin
    if (!rst_n) begin
      r_ph            <= '0;
      r_cell          <= c_cell_y;
      r_skip          <= 1'b0;
      r_prev          <= 1'b0;
      r_pend_vld      <= 1'b0;
      r_pend_bit      <= 1'b0;
      r_shift         <= '0;
      r_bit_cnt       <= '0;
      r_rx_data       <= '0;
      r_rx_bits       <= '0;
      r_rx_valid      <= 1'b0;
      r_rx_parity_err <= 1'b0;
      r_rx_sof        <= 1'b0;
      r_rx_eof        <= 1'b0;
      r_rx_err        <= 1'b0;
    end else begin
      r_rx_sof        <= w_sof;
      r_rx_eof        <= w_eof;
      r_rx_err        <= w_err;
      r_rx_valid      <= 1'b0;
      r_rx_parity_err <= 1'b0;
      if (w_sof) begin
        r_ph       <= c_ph_d;
        r_cell     <= c_cell_y;
        r_skip     <= 1'b1;
        r_prev     <= 1'b0;
        r_pend_vld <= 1'b0;
        r_shift    <= '0;
        r_bit_cnt  <= '0;
      end else if (w_in_rx) begin
        r_ph <= (w_z_cur || w_z_early) ? c_ph_d : w_ph_next;
        // A Z event on a closing edge belongs to the cell that is opening.
        if (w_close) begin
          r_cell <= (w_z_cur || w_z_early) ? c_cell_z : c_cell_y;
          r_skip <= 1'b0;
        end else if (w_z_cur) begin
          r_cell <= c_cell_z;
        end else if (w_x) begin
          r_cell <= c_cell_x;
        end
        if (w_bit_ok) begin
          r_prev     <= w_dec_bit;
          r_pend_bit <= w_dec_bit;
          r_pend_vld <= 1'b1;
        end
        if (w_emit) begin
          if (w_byte) begin
            r_rx_valid      <= 1'b1;
            r_rx_data       <= r_shift;
            r_rx_bits       <= 4'd8;
            r_rx_parity_err <= ~^{r_pend_bit, r_shift};
            r_shift         <= '0;
            r_bit_cnt       <= '0;
          end else begin
            r_shift[r_bit_cnt[2:0]] <= r_pend_bit;
            r_bit_cnt               <= r_bit_cnt + 1'b1;
          end
        end
        if (w_eof && (r_bit_cnt != 4'd0)) begin
          r_rx_valid <= 1'b1;
          r_rx_data  <= r_shift;
          r_rx_bits  <= r_bit_cnt;
          r_shift    <= '0;
          r_bit_cnt  <= '0;
        end
      end
    end
  end

  assign rx_data       = r_rx_data;
  assign rx_bits       = r_rx_bits;
  assign rx_valid      = r_rx_valid;
  assign rx_parity_err = r_rx_parity_err;
  assign rx_sof        = r_rx_sof;
  assign rx_eof        = r_rx_eof;
  assign rx_err        = r_rx_err;
  assign rx_busy       = w_busy;

`ifdef HI_SIM_RX_CRC_EN
  logic [15:0] r_crc;
  logic        r_crc_ok;

  function automatic logic [15:0] f_crc_a(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] v_c;
    v_c = crc;
    for (int i = 0; i < 8; i++)
      v_c = (v_c[0] ^ data[i]) ? ((v_c >> 1) ^ 16'h8408) : (v_c >> 1);
    return v_c;
  endfunction

  // A frame ending in its own CRC_A leaves a zero residue.
  always_ff @(posedge ck_1356meg) begin
    if (!rst_n) begin
      r_crc    <= 16'h6363;
      r_crc_ok <= 1'b0;
    end else if (w_sof) begin
      r_crc    <= 16'h6363;
      r_crc_ok <= 1'b0;
    end else begin
      if (w_byte)
        r_crc <= f_crc_a(r_crc, r_shift);
      if (w_eof)
        r_crc_ok <= (r_crc == 16'h0000);
    end
  end

  assign rx_crc_ok = r_crc_ok;
`else
  assign rx_crc_ok = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hi_sim_miller_rx.sv
// ============================================================================
// Module   : tb_hi_sim_miller_rx
// Purpose  : Scoreboard bench for hi_sim_miller_rx (modified-Miller decoder).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_hi_sim_miller_rx;

  localparam int c_bp   = 128;
  localparam int c_plen = 24;
  localparam int K_SOF   = 0;
  localparam int K_VALID = 1;
  localparam int K_EOF   = 2;
  localparam int K_ERR   = 3;

  logic       ck_1356meg = 1'b0;
  logic       rst_n      = 1'b0;
  logic       carrier_in = 1'b1;
  logic [7:0] rx_data;
  logic [3:0] rx_bits;
  logic       rx_valid;
  logic       rx_parity_err;
  logic       rx_sof;
  logic       rx_eof;
  logic       rx_err;
  logic       rx_busy;
  logic       rx_crc_ok;

  always #5 ck_1356meg = ~ck_1356meg;

  hi_sim_miller_rx u_dut (
    .ck_1356meg    (ck_1356meg),
    .rst_n         (rst_n),
    .carrier_in    (carrier_in),
    .rx_data       (rx_data),
    .rx_bits       (rx_bits),
    .rx_valid      (rx_valid),
    .rx_parity_err (rx_parity_err),
    .rx_sof        (rx_sof),
    .rx_eof        (rx_eof),
    .rx_err        (rx_err),
    .rx_busy       (rx_busy),
    .rx_crc_ok     (rx_crc_ok)
  );

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic [3:0] nbits;
    logic       perr;
    logic       with_valid;
    logic       crc_ok;
  } ev_t;

  ev_t         sb_q[$];
  bit          tx_bits[$];
  bit          tx_prev;
  logic [15:0] m_crc;
  bit          m_last_partial;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc_a_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] v;
    v = c;
    for (int i = 0; i < 8; i++)
      v = (v[0] ^ d[i]) ? ((v >> 1) ^ 16'h8408) : (v >> 1);
    return v;
  endfunction

  task automatic push_ev(input int kind, input logic [7:0] d, input logic [3:0] n,
                         input logic p, input logic wv, input logic co);
    ev_t e;
    e.kind = kind; e.data = d; e.nbits = n; e.perr = p; e.with_valid = wv; e.crc_ok = co;
    sb_q.push_back(e);
  endtask

  task automatic take(input int kind, input string tag, output ev_t e, output bit got);
    got = 1'b0;
    chk({tag, "_expected"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_kind"}, e.kind, kind);
      got = (e.kind == kind);
    end
  endtask

  always @(negedge ck_1356meg) begin : mon
    ev_t e;
    bit  ok;
    if (rx_sof) begin
      take(K_SOF, "sof", e, ok);
      chk("sof_busy", 32'(rx_busy), 32'd1);
    end
    if (rx_valid) begin
      take(K_VALID, "valid", e, ok);
      if (ok) begin
        chk("valid_data", 32'(rx_data), 32'(e.data));
        chk("valid_bits", 32'(rx_bits), 32'(e.nbits));
        chk("valid_perr", 32'(rx_parity_err), 32'(e.perr));
      end
    end
    if (rx_eof) begin
      take(K_EOF, "eof", e, ok);
      if (ok) begin
        chk("eof_with_valid", 32'(rx_valid), 32'(e.with_valid));
        chk("eof_crc_ok", 32'(rx_crc_ok), 32'(e.crc_ok));
      end
      chk("eof_busy", 32'(rx_busy), 32'd0);
      chk("eof_no_err", 32'(rx_err), 32'd0);
    end
    if (rx_err) begin
      take(K_ERR, "err", e, ok);
      chk("err_busy", 32'(rx_busy), 32'd0);
    end
  end

  // One bit cell; carrier changes 1 ns after each rising edge.
  task automatic drive_cell(input int pause_at, input int plen, input int glitch_at);
    for (int i = 0; i < c_bp; i++) begin
      @(posedge ck_1356meg);
      #1;
      carrier_in = ~((pause_at >= 0 && i >= pause_at && i < pause_at + plen) ||
                     (glitch_at >= 0 && i >= glitch_at && i < glitch_at + 5));
    end
  endtask

  task automatic send_bit(input bit b, input int glitch_at);
    if (b)            drive_cell(64, c_plen, glitch_at);
    else if (tx_prev) drive_cell(-1, 0, glitch_at);
    else              drive_cell(0, c_plen, glitch_at);
    tx_prev = b;
  endtask

  task automatic send_sof();
    drive_cell(0, c_plen, -1);
    tx_prev = 1'b0;
  endtask

  task automatic begin_frame();
    push_ev(K_SOF, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    m_crc          = 16'h6363;
    m_last_partial = 1'b0;
    tx_bits.delete();
  endtask

  task automatic add_byte(input logic [7:0] d, input bit flip_par);
    for (int i = 0; i < 8; i++) tx_bits.push_back(d[i]);
    tx_bits.push_back((~^d) ^ flip_par);
    push_ev(K_VALID, d, 4'd8, flip_par, 1'b0, 1'b0);
    m_crc = crc_a_byte(m_crc, d);
  endtask

  task automatic add_partial(input logic [7:0] d, input int n);
    logic [7:0] mask;
    mask = 8'((9'd1 << n) - 9'd1);
    for (int i = 0; i < n; i++) tx_bits.push_back(d[i]);
    push_ev(K_VALID, d & mask, 4'(n), 1'b0, 1'b0, 1'b0);
    m_last_partial = 1'b1;
  endtask

  task automatic send_frame(input int glitch_idx);
    logic exp_crc;
`ifdef HI_SIM_RX_CRC_EN
    exp_crc = (m_crc == 16'h0000);
`else
    exp_crc = 1'b0;
`endif
    push_ev(K_EOF, 8'h00, 4'd0, 1'b0, m_last_partial, exp_crc);
    send_sof();
    for (int i = 0; i < tx_bits.size(); i++)
      send_bit(tx_bits[i], (i == glitch_idx) ? 30 : -1);
    send_bit(1'b0, -1);
    repeat (3) drive_cell(-1, 0, -1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d events still expected", sb_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst_n      = 1'b0;
    carrier_in = 1'b1;
    repeat (4) @(posedge ck_1356meg);
    #1;
    chk("reset_outputs", 32'({rx_data, rx_bits, rx_valid, rx_parity_err, rx_sof,
                              rx_eof, rx_err, rx_busy, rx_crc_ok}), 32'd0);
    rst_n = 1'b1;
    drive_cell(-1, 0, -1);

    // REQA: 7-bit short frame
    begin_frame(); add_partial(8'h26, 7); send_frame(-1);

    // SEL with correct parity
    begin_frame(); add_byte(8'h93, 1'b0); add_byte(8'h20, 1'b0); send_frame(-1);

    // Inverted parity bit: flagged, frame still completes
    begin_frame(); add_byte(8'h93, 1'b1); send_frame(-1);

    // 5-clock glitch inside a cell must not disturb decoding
    begin_frame(); add_byte(8'h93, 1'b0); add_byte(8'h20, 1'b0); send_frame(5);

    // Pause landing at phase 40 is a framing error
    push_ev(K_SOF, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    send_sof(); send_bit(1'b1, -1); send_bit(1'b0, -1);
    push_ev(K_ERR, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    drive_cell(32, c_plen, -1);
    drive_cell(-1, 0, -1);

    // Next SOF after the error is accepted
    begin_frame(); add_partial(8'h26, 7); send_frame(-1);

    // Carrier loss: low run reaching PAUSE_MAX inside a frame
    push_ev(K_SOF, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    send_sof(); send_bit(1'b0, -1);
    push_ev(K_ERR, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    drive_cell(0, 90, -1);
    drive_cell(-1, 0, -1);

    // One-clock reset in the middle of a byte aborts silently
    push_ev(K_SOF, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    send_sof(); send_bit(1'b1, -1); send_bit(1'b0, -1); send_bit(1'b1, -1);
    for (int i = 0; i < 40; i++) begin
      @(posedge ck_1356meg);
      #1;
    end
    chk("busy_before_reset", 32'(rx_busy), 32'd1);
    rst_n = 1'b0;
    @(posedge ck_1356meg);
    #1;
    rst_n = 1'b1;
    chk("outputs_after_reset", 32'({rx_data, rx_bits, rx_valid, rx_parity_err, rx_sof,
                                    rx_eof, rx_err, rx_busy, rx_crc_ok}), 32'd0);
    repeat (2) drive_cell(-1, 0, -1);
    begin_frame(); add_byte(8'h93, 1'b0); add_byte(8'h20, 1'b0); send_frame(-1);

    // HLTA with valid CRC_A, then with a corrupted CRC byte
    begin_frame();
    add_byte(8'h50, 1'b0); add_byte(8'h00, 1'b0); add_byte(8'h57, 1'b0); add_byte(8'hCD, 1'b0);
    send_frame(-1);
    begin_frame();
    add_byte(8'h50, 1'b0); add_byte(8'h00, 1'b0); add_byte(8'h57, 1'b0); add_byte(8'hCC, 1'b0);
    send_frame(-1);

    // EOF with no data bits: rx_eof alone
    begin_frame(); send_frame(-1);

    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
